// File: rtl/alu_cmd_driver_if.sv
// Command/response bundle between a command source and the ALU command driver.
// Latency: none, wires only.
// Backpressure: valid/ready on both the command and response channels.
interface alu_cmd_driver_if #(
   parameter int DATA_W = 8,
   parameter int AOP_W  = 3,
   parameter int BOP_W  = 2
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;
   logic [AOP_W-1:0]  cmd_a_op;
   logic [BOP_W-1:0]  cmd_b_op;
   logic              cmd_a_en;
   logic              cmd_b_en;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_c;

   // command source / response consumer side
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_a_op, cmd_b_op, cmd_a_en, cmd_b_en, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_c
   );

   // driver side
   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_a_op, cmd_b_op, cmd_a_en, cmd_b_en, rsp_ready,
      output cmd_ready, rsp_valid, rsp_c
   );
endinterface

// File: rtl/alu_cmd_driver.sv
// Drives one ALU operation per accepted command and returns the captured result.
// Latency: rsp_valid rises ALU_LAT+1 edges after the accept edge; all outputs registered.
// Backpressure: one command in flight; cmd_ready stays low until the response is taken.
module alu_cmd_driver #(
   parameter int DATA_W  = 8,
   parameter int AOP_W   = 3,
   parameter int BOP_W   = 2,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   alu_cmd_driver_if.slave   io,
   output logic              ALU_en,
   output logic              a_en,
   output logic              b_en,
   output logic [AOP_W-1:0]  a_op,
   output logic [BOP_W-1:0]  b_op,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   output logic              busy,
   output logic [CNT_W-1:0]  cmd_cnt,
   output logic [CNT_W-1:0]  rsp_cnt
);

   localparam int WCNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   logic              accept;
   logic              rsp_hs;
   logic              wait_done;

   // clr masks both handshakes so an abort never counts as accept or delivery
   assign accept    = io.cmd_valid & io.cmd_ready & ~clr;
   assign rsp_hs    = io.rsp_valid & io.rsp_ready & ~clr;
   assign wait_done = (state == S_WAIT) && (wait_cnt == WCNT_W'(1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state: clr wins over everything, otherwise walk IDLE->DRIVE->WAIT->RESP
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept)    state_nxt = S_DRIVE;
            S_DRIVE:                state_nxt = S_WAIT;
            S_WAIT:  if (wait_done) state_nxt = S_RESP;
            S_RESP:  if (rsp_hs)    state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
         endcase
      end
   end

   // latency countdown, armed during the DRIVE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     wait_cnt <= '0;
      else if (state == S_DRIVE)                      wait_cnt <= WCNT_W'(ALU_LAT);
      else if (state == S_WAIT && wait_cnt != '0)     wait_cnt <= wait_cnt - WCNT_W'(1);
   end

   // control outputs follow the next state so they are registered yet aligned with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.cmd_ready <= 1'b0;
         ALU_en       <= 1'b0;
         io.rsp_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         io.cmd_ready <= (state_nxt == S_IDLE);
         ALU_en       <= (state_nxt == S_DRIVE);
         io.rsp_valid <= (state_nxt == S_RESP);
         busy         <= (state_nxt != S_IDLE);
      end
   end

   // operands and opcodes are latched on accept and held until the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A    <= '0;
         B    <= '0;
         a_op <= '0;
         b_op <= '0;
         a_en <= 1'b0;
         b_en <= 1'b0;
      end else if (accept) begin
         A    <= io.cmd_a;
         B    <= io.cmd_b;
         a_op <= io.cmd_a_op;
         b_op <= io.cmd_b_op;
         a_en <= io.cmd_a_en;
         b_en <= io.cmd_b_en;
      end
   end

   // result capture at the end of the last WAIT cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                io.rsp_c <= '0;
      else if (wait_done && !clr) io.rsp_c <= C;
   end

   // status counters, wrapping silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_cnt <= '0;
         rsp_cnt <= '0;
      end else begin
         if (accept) cmd_cnt <= cmd_cnt + CNT_W'(1);
         if (rsp_hs) rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench: u1 (ALU_LAT=1, CNT_W=4) for reset/single/backpressure/clr/wrap,
// u3 (ALU_LAT=3, CNT_W=16) for back-to-back throughput.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_cmd_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr1, clr3;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   alu_cmd_driver_if #(.DATA_W(8), .AOP_W(3), .BOP_W(2)) c1 ();
   alu_cmd_driver_if #(.DATA_W(8), .AOP_W(3), .BOP_W(2)) c3 ();

   logic       alu_en1, a_en1, b_en1, busy1;
   logic [2:0] a_op1;
   logic [1:0] b_op1;
   logic [7:0] A1, B1, C1;
   logic [3:0] cmd_cnt1, rsp_cnt1;

   logic        alu_en3, a_en3, b_en3, busy3;
   logic [2:0]  a_op3;
   logic [1:0]  b_op3;
   logic [7:0]  A3, B3, C3;
   logic [15:0] cmd_cnt3, rsp_cnt3;

   // reference ALU: A-group takes precedence when both enables are set
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] aop, input logic [1:0] bop,
                                        input logic aen, input logic ben);
      logic [7:0] r;
      r = 8'h00;
      if (aen) begin
         case (aop)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a ^ b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            3'd6: r = {a[6:0], 1'b0};
            default: r = {1'b0, a[7:1]};
         endcase
      end else if (ben) begin
         case (bop)
            2'd0: r = ~(a & b);
            2'd1: r = ~(a | b);
            2'd2: r = ~(a ^ b);
            default: r = b;
         endcase
      end
      return r;
   endfunction

   assign C1 = alu_f(A1, B1, a_op1, b_op1, a_en1, b_en1);
   assign C3 = alu_f(A3, B3, a_op3, b_op3, a_en3, b_en3);

   alu_cmd_driver #(.DATA_W(8), .AOP_W(3), .BOP_W(2), .ALU_LAT(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr1), .io(c1.slave),
      .ALU_en(alu_en1), .a_en(a_en1), .b_en(b_en1), .a_op(a_op1), .b_op(b_op1),
      .A(A1), .B(B1), .C(C1), .busy(busy1), .cmd_cnt(cmd_cnt1), .rsp_cnt(rsp_cnt1)
   );

   alu_cmd_driver #(.DATA_W(8), .AOP_W(3), .BOP_W(2), .ALU_LAT(3), .CNT_W(16)) u3 (
      .clk(clk), .rst_n(rst_n), .clr(clr3), .io(c3.slave),
      .ALU_en(alu_en3), .a_en(a_en3), .b_en(b_en3), .a_op(a_op3), .b_op(b_op3),
      .A(A3), .B(B3), .C(C3), .busy(busy3), .cmd_cnt(cmd_cnt3), .rsp_cnt(rsp_cnt3)
   );

   // ALU_en high-cycle count for u1, sampled at the rising edge
   int en1_cnt = 0;
   always @(posedge clk) if (alu_en1 === 1'b1) en1_cnt <= en1_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] aop,
                         input logic [1:0] bop, input logic aen, input logic ben);
      c1.cmd_a = a; c1.cmd_b = b; c1.cmd_a_op = aop; c1.cmd_b_op = bop;
      c1.cmd_a_en = aen; c1.cmd_b_en = ben; c1.cmd_valid = 1'b1;
   endtask

   logic [7:0] ra, rb, rexp;
   logic [2:0] rao;
   logic [1:0] rbo;
   logic       rae, rbe, found;
   int         e0, last_acc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clr1 = 1'b0; clr3 = 1'b0;
      c1.cmd_valid = 1'b0; c1.cmd_a = '0; c1.cmd_b = '0; c1.cmd_a_op = '0; c1.cmd_b_op = '0;
      c1.cmd_a_en = 1'b0; c1.cmd_b_en = 1'b0; c1.rsp_ready = 1'b0;
      c3.cmd_valid = 1'b0; c3.cmd_a = '0; c3.cmd_b = '0; c3.cmd_a_op = '0; c3.cmd_b_op = '0;
      c3.cmd_a_en = 1'b0; c3.cmd_b_en = 1'b0; c3.rsp_ready = 1'b0;

      // 1: reset and idle
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl1", 32'({c1.cmd_ready, alu_en1, c1.rsp_valid, busy1}), 0);
      chk("rst_ops1", 32'({A1, B1, a_op1, b_op1, a_en1, b_en1}), 0);
      chk("rst_cnt1", 32'({cmd_cnt1, rsp_cnt1, c1.rsp_c}), 0);
      chk("rst_ctl3", 32'({c3.cmd_ready, alu_en3, c3.rsp_valid, busy3}), 0);
      chk("rst_cnt3", 32'({cmd_cnt3, rsp_cnt3}), 0);
      rst_n = 1'b1;
      chk("release_no_comb", 32'(c1.cmd_ready), 0);
      @(negedge clk);
      chk("ready_after_release", 32'({c1.cmd_ready, c3.cmd_ready}), 32'h3);
      chk("no_en_pulse_idle", 32'(en1_cnt), 0);

      // 2: single op, 12+34
      e0 = en1_cnt;
      drive1(8'h12, 8'h34, 3'd0, 2'd0, 1'b1, 1'b0);
      c1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t2_alu_en", 32'(alu_en1), 1);
      chk("t2_ab", 32'({A1, B1}), 32'h1234);
      chk("t2_en_op", 32'({a_en1, b_en1, a_op1}), 32'h10);
      chk("t2_busy_ready", 32'({busy1, c1.cmd_ready}), 32'h2);
      chk("t2_cmd_cnt", 32'(cmd_cnt1), 1);
      c1.cmd_valid = 1'b0;
      @(negedge clk);
      chk("t2_en_drop", 32'({alu_en1, c1.rsp_valid}), 0);
      @(negedge clk);
      chk("t2_rsp_valid", 32'(c1.rsp_valid), 1);
      chk("t2_rsp_c", 32'(c1.rsp_c), 32'h46);
      @(negedge clk);
      chk("t2_idle", 32'({c1.rsp_valid, c1.cmd_ready, busy1}), 32'h2);
      chk("t2_cnts", 32'({cmd_cnt1, rsp_cnt1}), 32'h11);
      chk("t2_pulse", 32'(en1_cnt - e0), 1);
      chk("t2_hold_ab", 32'({A1, B1}), 32'h1234);

      // 3: response backpressure for 5 cycles
      e0 = en1_cnt;
      drive1(8'hF0, 8'h0F, 3'd7, 2'd0, 1'b0, 1'b1);
      c1.rsp_ready = 1'b0;
      @(negedge clk);
      c1.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(c1.rsp_valid), 1);
         chk("t3_hold_c", 32'(c1.rsp_c), 32'hFF);
         chk("t3_hold_ready_en", 32'({c1.cmd_ready, alu_en1}), 0);
         @(negedge clk);
      end
      chk("t3_still_valid", 32'(c1.rsp_valid), 1);
      c1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_idle", 32'({c1.rsp_valid, c1.cmd_ready, busy1}), 32'h2);
      chk("t3_cnts", 32'({cmd_cnt1, rsp_cnt1}), 32'h22);
      chk("t3_pulse", 32'(en1_cnt - e0), 1);

      // 4: clr during WAIT with cmd_valid held high
      drive1(8'h05, 8'h03, 3'd1, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("t4_in_wait", 32'({busy1, c1.rsp_valid, c1.cmd_ready}), 32'h4);
      clr1 = 1'b1;
      @(negedge clk);
      chk("t4_abort", 32'({c1.rsp_valid, c1.cmd_ready, busy1, alu_en1}), 32'h4);
      chk("t4_cnts", 32'({cmd_cnt1, rsp_cnt1}), 32'h32);
      chk("t4_hold_a", 32'(A1), 32'h05);
      clr1 = 1'b0;
      @(negedge clk);
      chk("t4_reaccept", 32'({alu_en1, cmd_cnt1}), 32'h14);
      c1.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4_rsp", 32'({c1.rsp_valid, c1.rsp_c}), 32'h102);
      @(negedge clk);
      chk("t4_rsp_cnt", 32'(rsp_cnt1), 3);

      // reset asserted mid-operation
      drive1(8'hAA, 8'h55, 3'd4, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      c1.cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rmid_ctl", 32'({alu_en1, c1.rsp_valid, c1.cmd_ready, busy1}), 0);
      chk("rmid_ops", 32'({A1, B1, cmd_cnt1, rsp_cnt1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rmid_recover", 32'({c1.cmd_ready, c1.rsp_valid}), 32'h2);

      // 6: counter wrap, 17 ops on the 4-bit counters
      for (int k = 0; k < 17; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rao = 3'($urandom); rbo = 2'($urandom);
         rae = 1'($urandom); rbe = 1'($urandom);
         rexp = alu_f(ra, rb, rao, rbo, rae, rbe);
         drive1(ra, rb, rao, rbo, rae, rbe);
         @(negedge clk);
         c1.cmd_valid = 1'b0;
         chk("t6_drive", 32'({alu_en1, a_en1, b_en1}), 32'({1'b1, rae, rbe}));
         @(negedge clk);
         chk("t6_no_early", 32'(c1.rsp_valid), 0);
         @(negedge clk);
         chk("t6_rsp", 32'({c1.rsp_valid, c1.rsp_c}), 32'({1'b1, rexp}));
         @(negedge clk);
      end
      chk("t6_wrap", 32'({cmd_cnt1, rsp_cnt1}), 32'h11);

      // 5: back-to-back on u3, ALU_LAT=3
      c3.rsp_ready = 1'b1;
      last_acc = 0;
      ra = 8'($urandom); rb = 8'($urandom); rao = 3'($urandom); rbo = 2'($urandom);
      rae = 1'($urandom); rbe = 1'($urandom);
      c3.cmd_a = ra; c3.cmd_b = rb; c3.cmd_a_op = rao; c3.cmd_b_op = rbo;
      c3.cmd_a_en = rae; c3.cmd_b_en = rbe; c3.cmd_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         rexp = alu_f(ra, rb, rao, rbo, rae, rbe);
         found = 1'b0;
         for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk);
            if (alu_en3 === 1'b1) found = 1'b1;
         end
         if (!found) begin
            chk("t5_accept_timeout", 0, 1);
            break;
         end
         if (k > 0) chk("t5_spacing", 32'(cyc - last_acc), 6);
         last_acc = cyc;
         found = 1'b0;
         for (int w = 1; w <= 20 && !found; w++) begin
            @(negedge clk);
            if (c3.rsp_valid === 1'b1) begin
               found = 1'b1;
               chk("t5_latency", 32'(w), 4);
            end
         end
         if (!found) begin
            chk("t5_rsp_timeout", 0, 1);
            break;
         end
         chk("t5_rsp_c", 32'(c3.rsp_c), 32'(rexp));
         if (k < 299) begin
            ra = 8'($urandom); rb = 8'($urandom); rao = 3'($urandom); rbo = 2'($urandom);
            rae = 1'($urandom); rbe = 1'($urandom);
            c3.cmd_a = ra; c3.cmd_b = rb; c3.cmd_a_op = rao; c3.cmd_b_op = rbo;
            c3.cmd_a_en = rae; c3.cmd_b_en = rbe;
         end else begin
            c3.cmd_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("t5_cmd_cnt", 32'(cmd_cnt3), 300);
      chk("t5_rsp_cnt", 32'(rsp_cnt3), 300);
      chk("t5_idle", 32'({busy3, c3.cmd_ready}), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
